id_queue_stage: RTL and testbench
=================================

# id_queue_stage

Parametrised instruction-decode stage with an elastic output queue. It sits between fetch and execute and replaces the single-latch decode stage. Each accepted instruction is decoded on entry and stored as a decoded bundle in a DEPTH-entry FIFO. Fetch and execute are decoupled by valid/ready handshakes; the block also supports a hazard bubble (stall) and a pipeline flush.

## Interface
Parameters:
- PC_W, 12, program-counter width.
- DEPTH, 2, number of queue entries; must be at least 1; need not be a power of two.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable_in  in  1  global pipeline enable; when low, the queue is frozen.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept an instruction.
- pc_in  in  PC_W  instruction PC.
- instr_in  in  12  instruction word.
- instr_set_in  in  4  active instruction set (`ISET_*`).
- stall_in  in  1  hazard stall; head is held and a bubble is presented.
- flush_in  in  1  synchronous queue flush.
- out_valid  out  1  head bundle valid for execute.
- out_ready  in  1  execute accepts the head bundle.
- pc_out  out  PC_W  head PC.
- instr_out  out  12  head instruction, NOP-squashed.
- instr_set_out  out  4  head instruction set.
- bcc_out, tgt_gp_out, tgt_sr_out, src_gp_out, src_sr_out  out  4 each  decoded fields.
- imm_en_out, imm_hilo_out, sgn_en_out  out  1 each  decoded flags.
- imm_val_out, off_out  out  6 each  immediate and offset.
- count_out  out  CNT_W  current occupancy.

## Operation
Decode is combinational on the input side and is captured at enqueue. With op = instr_in[11:8] and set = instr_set_in:
- instr = 0 if op == `OPC_NOP`, else instr_in; all remaining fields are taken from this squashed instr.
- bcc = instr[7:4].
- tgt_gp = instr[7:4] only if set != `ISET_S` and reg_tgt_read_fn(set, op); otherwise 0.
- src_gp = instr[3:0] only if set != `ISET_S` and reg_src_read_fn(set, op); otherwise 0.
- tgt_sr = instr[7:4] and src_sr = instr[3:0] if set == `ISET_S`; otherwise 0.
- imm_hilo = instr[7]; imm_val = off = instr[5:0].
- sgn_en = (set == `ISET_RS` or set == `ISET_IS`).
- imm_en = (set == `ISET_I` or set == `ISET_IS`), and not Li (`ISET_I`/`OPC_I_Li`), and not Lis (`ISET_IS`/`OPC_IS_Lis`).

Queue behaviour:
- enq = enable_in & in_valid & in_ready & !flush_in.
- deq = enable_in & out_valid & out_ready & !flush_in.
- in_ready = enable_in & (count < DEPTH). It has no combinational path from out_ready, so a full queue refuses an enqueue even when a dequeue happens in the same cycle.
- out_valid = enable_in & (count != 0) & !stall_in.
- Head and tail pointers wrap from DEPTH-1 to 0.
- Simultaneous enq and deq: count is unchanged and both pointers advance.
- flush_in has priority over enq and deq. It zeroes count and both pointers on the next edge; any instruction offered in that cycle is dropped.
- Output presentation:
  - count != 0 and !stall_in: all outputs show the head bundle.
  - stall_in with count != 0: pc_out and instr_set_out show the head entry; instr_out and all decoded fields are 0 (bubble). The head is not consumed.
  - Empty: all outputs are 0 and instr_set_out = `ISET_R`.
- When enable_in is low, nothing moves and the outputs still reflect the stored head.

## Timing
- Reset (asynchronous) values: count_out = 0, pointers = 0, out_valid = 0, in_ready = 0 while enable_in is low (1 after reset with enable_in high), all data outputs 0, instr_set_out = `ISET_R`.
- Latency: an instruction enqueued at edge N is valid on the outputs after edge N, provided the queue was empty; one cycle, with no bypass.
- Throughput: one enq and one deq per cycle when not full.
- flush_in asserted in cycle N: out_valid = 0 and in_ready = 1 after edge N.
- stall_in takes effect combinationally in the same cycle. Deasserting it re-presents the same head.
- Reset mid-operation discards all entries immediately.

## Test plan
- Single instruction (DEPTH=2). Enqueue pc=0x010, instr=0x312 with set `ISET_R` and op 3 reading both registers. Response: one cycle later out_valid=1, pc_out=0x010, tgt_gp_out=1, src_gp_out=2, tgt_sr_out=src_sr_out=0, imm_en_out=0.
- Fill, backpressure and wrap. Hold out_ready=0 and offer 3 instructions: in_ready drops after the 2nd and count_out=2. Then run 8 back-to-back instructions with out_ready=1. Response: in-order output, no loss, pointer wrap exercised. Repeat with DEPTH=3.
- Stall bubble. Head pc=0x020, instr=0x5AB; assert stall_in for 2 cycles. Response: out_valid=0, pc_out=0x020, instr_out=0, decoded fields 0, count_out unchanged. After release the same head is presented with instr_out=0x5AB.
- Flush collision. Queue holds 2 entries; in one cycle assert flush_in with in_valid=1 and out_ready=1. Response: next cycle count_out=0, out_valid=0, and the offered instruction does not appear.
- Decode corners:
  - `OPC_NOP` with instr=0x0FF gives instr_out=0.
  - `ISET_S` with instr=0x1C5 gives tgt_sr_out=0xC, src_sr_out=5, gp fields 0.
  - Li gives imm_en_out=0.
  - `ISET_IS` non-Lis gives imm_en_out=1 and sgn_en_out=1.
- Asynchronous reset with 2 entries queued, asserted between edges. Response: outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_queue_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode queue stage.
// The stage itself connects through the slave modport; the driver of both sides uses master.
interface id_queue_stage_if #(
  parameter int PC_W  = 12,
  parameter int DEPTH = 2
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             enable_in;
  logic             in_valid;
  logic             in_ready;
  logic [PC_W-1:0]  pc_in;
  logic [11:0]      instr_in;
  logic [3:0]       instr_set_in;
  logic             stall_in;
  logic             flush_in;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  pc_out;
  logic [11:0]      instr_out;
  logic [3:0]       instr_set_out;
  logic [3:0]       bcc_out;
  logic [3:0]       tgt_gp_out;
  logic [3:0]       tgt_sr_out;
  logic [3:0]       src_gp_out;
  logic [3:0]       src_sr_out;
  logic             imm_en_out;
  logic             imm_hilo_out;
  logic             sgn_en_out;
  logic [5:0]       imm_val_out;
  logic [5:0]       off_out;
  logic [CNT_W-1:0] count_out;

  modport slave (
    input  enable_in, in_valid, pc_in, instr_in, instr_set_in, stall_in, flush_in, out_ready,
    output in_ready, out_valid, pc_out, instr_out, instr_set_out, bcc_out, tgt_gp_out,
           tgt_sr_out, src_gp_out, src_sr_out, imm_en_out, imm_hilo_out, sgn_en_out,
           imm_val_out, off_out, count_out
  );

  modport master (
    output enable_in, in_valid, pc_in, instr_in, instr_set_in, stall_in, flush_in, out_ready,
    input  in_ready, out_valid, pc_out, instr_out, instr_set_out, bcc_out, tgt_gp_out,
           tgt_sr_out, src_gp_out, src_sr_out, imm_en_out, imm_hilo_out, sgn_en_out,
           imm_val_out, off_out, count_out
  );
endinterface

// File: rtl/id_queue_stage.sv
// Decode stage feeding a DEPTH-entry FIFO of decoded bundles; 1-cycle enqueue-to-output latency, no bypass.
// Backpressure: in_ready depends only on occupancy (a full queue refuses even on a same-cycle dequeue).
module id_queue_stage #(
  parameter int PC_W  = 12,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  id_queue_stage_if.slave q
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] ISET_R     = 4'd0;
  localparam logic [3:0] ISET_I     = 4'd1;
  localparam logic [3:0] ISET_S     = 4'd2;
  localparam logic [3:0] ISET_RS    = 4'd3;
  localparam logic [3:0] ISET_IS    = 4'd4;
  localparam logic [3:0] OPC_NOP    = 4'h0;
  localparam logic [3:0] OPC_I_Li   = 4'h1;
  localparam logic [3:0] OPC_IS_Lis = 4'h1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [11:0]     instr;
    logic [3:0]      iset;
    logic [3:0]      bcc;
    logic [3:0]      tgt_gp;
    logic [3:0]      tgt_sr;
    logic [3:0]      src_gp;
    logic [3:0]      src_sr;
    logic            imm_en;
    logic            imm_hilo;
    logic            sgn_en;
    logic [5:0]      imm_val;
    logic [5:0]      off;
  } bundle_t;

  // Ops 1..B are ALU ops reading the target as left operand; C..F are branches; loads-immediate only write.
  function automatic logic reg_tgt_read_fn(input logic [3:0] set, input logic [3:0] op);
    logic imm_load;
    imm_load = (set == ISET_I && op == OPC_I_Li) || (set == ISET_IS && op == OPC_IS_Lis);
    return (op != OPC_NOP) && (op < 4'hC) && !imm_load;
  endfunction

  // Only the register-register sets take a second register; immediate sets use the immediate instead.
  function automatic logic reg_src_read_fn(input logic [3:0] set, input logic [3:0] op);
    return (set == ISET_R || set == ISET_RS) && (op != OPC_NOP) && (op < 4'hC);
  endfunction

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  bundle_t          mem [DEPTH];
  bundle_t          dec;
  bundle_t          hd;
  bundle_t          shown;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [3:0]       op, set;
  logic             enq, deq, ready, valid;

  always_comb begin
    op  = q.instr_in[11:8];
    set = q.instr_set_in;
    dec = '0;
    dec.pc       = q.pc_in;
    dec.iset     = set;
    dec.instr    = (op == OPC_NOP) ? 12'h000 : q.instr_in;
    dec.bcc      = dec.instr[7:4];
    if (set == ISET_S) begin
      dec.tgt_sr = dec.instr[7:4];
      dec.src_sr = dec.instr[3:0];
    end else begin
      if (reg_tgt_read_fn(set, op)) dec.tgt_gp = dec.instr[7:4];
      if (reg_src_read_fn(set, op)) dec.src_gp = dec.instr[3:0];
    end
    dec.imm_hilo = dec.instr[7];
    dec.imm_val  = dec.instr[5:0];
    dec.off      = dec.instr[5:0];
    dec.sgn_en   = (set == ISET_RS) || (set == ISET_IS);
    dec.imm_en   = ((set == ISET_I) || (set == ISET_IS))
                 && !(set == ISET_I && op == OPC_I_Li)
                 && !(set == ISET_IS && op == OPC_IS_Lis);
  end

  assign ready = q.enable_in && (count < CNT_W'(DEPTH));
  assign valid = q.enable_in && (count != '0) && !q.stall_in;
  assign enq   = q.enable_in && q.in_valid && ready && !q.flush_in;
  assign deq   = q.enable_in && valid && q.out_ready && !q.flush_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (q.enable_in && q.flush_in) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (enq) tail <= wrap_inc(tail);
      if (deq) head <= wrap_inc(head);
      if (enq && !deq)      count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= dec;
  end

  // A stalled head keeps its pc and set visible so execute can see what is being held.
  always_comb begin
    hd    = mem[head];
    shown = '0;
    shown.iset = ISET_R;
    if (count != '0) begin
      if (q.stall_in) begin
        shown.pc   = hd.pc;
        shown.iset = hd.iset;
      end else begin
        shown = hd;
      end
    end
  end

  assign q.in_ready      = ready;
  assign q.out_valid     = valid;
  assign q.count_out     = count;
  assign q.pc_out        = shown.pc;
  assign q.instr_out     = shown.instr;
  assign q.instr_set_out = shown.iset;
  assign q.bcc_out       = shown.bcc;
  assign q.tgt_gp_out    = shown.tgt_gp;
  assign q.tgt_sr_out    = shown.tgt_sr;
  assign q.src_gp_out    = shown.src_gp;
  assign q.src_sr_out    = shown.src_sr;
  assign q.imm_en_out    = shown.imm_en;
  assign q.imm_hilo_out  = shown.imm_hilo;
  assign q.sgn_en_out    = shown.sgn_en;
  assign q.imm_val_out   = shown.imm_val;
  assign q.off_out       = shown.off;
endmodule

// File: tb/tb_id_queue_stage.sv
// Directed bench for id_queue_stage: DEPTH=2 instance for most scenarios, DEPTH=3 for fill/wrap.
module tb_id_queue_stage;
  localparam logic [3:0] ISET_R  = 4'd0;
  localparam logic [3:0] ISET_I  = 4'd1;
  localparam logic [3:0] ISET_S  = 4'd2;
  localparam logic [3:0] ISET_RS = 4'd3;
  localparam logic [3:0] ISET_IS = 4'd4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  id_queue_stage_if #(.PC_W(12), .DEPTH(2)) q2 ();
  id_queue_stage_if #(.PC_W(12), .DEPTH(3)) q3 ();
  id_queue_stage #(.PC_W(12), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .q(q2));
  id_queue_stage #(.PC_W(12), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .q(q3));

  // {bcc, tgt_gp, tgt_sr, src_gp, src_sr, imm_en, imm_hilo, sgn_en, imm_val, off}
  function automatic logic [34:0] fields2();
    return {q2.bcc_out, q2.tgt_gp_out, q2.tgt_sr_out, q2.src_gp_out, q2.src_sr_out,
            q2.imm_en_out, q2.imm_hilo_out, q2.sgn_en_out, q2.imm_val_out, q2.off_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load2(input logic [11:0] pc, input logic [11:0] instr, input logic [3:0] set);
    q2.in_valid = 1'b1; q2.pc_in = pc; q2.instr_in = instr; q2.instr_set_in = set;
    tick();
    q2.in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q2.enable_in = 1'b0; q2.in_valid = 1'b0; q2.pc_in = '0; q2.instr_in = '0;
    q2.instr_set_in = ISET_R; q2.stall_in = 1'b0; q2.flush_in = 1'b0; q2.out_ready = 1'b0;
    q3.enable_in = 1'b0; q3.in_valid = 1'b0; q3.pc_in = '0; q3.instr_in = '0;
    q3.instr_set_in = ISET_R; q3.stall_in = 1'b0; q3.flush_in = 1'b0; q3.out_ready = 1'b0;
    #1;
    total++;
    if ({q2.count_out, q2.out_valid, q2.in_ready} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {q2.count_out, q2.out_valid, q2.in_ready});
    end
    total++;
    if ({q2.pc_out, q2.instr_out, q2.instr_set_out, fields2()} !== {12'h0, 12'h0, ISET_R, 35'h0}) begin
      bad++; $display("FAIL reset_data pc=%h instr=%h set=%h fields=%h", q2.pc_out, q2.instr_out, q2.instr_set_out, fields2());
    end
    q2.enable_in = 1'b1; q3.enable_in = 1'b1;
    #1;
    total++;
    if (q2.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", q2.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    load2(12'h010, 12'h312, ISET_R);
    total++;
    if ({q2.out_valid, q2.pc_out, q2.instr_out, q2.count_out} !== {1'b1, 12'h010, 12'h312, 2'd1}) begin
      bad++; $display("FAIL single_head vld=%b pc=%h instr=%h cnt=%0d want 1/010/312/1", q2.out_valid, q2.pc_out, q2.instr_out, q2.count_out);
    end
    total++;
    if (fields2() !== {4'h1, 4'h1, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 6'h12, 6'h12}) begin
      bad++; $display("FAIL single_fields got=%h want=%h", fields2(), {4'h1, 4'h1, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 6'h12, 6'h12});
    end
    q2.out_ready = 1'b1;
    tick();
    q2.out_ready = 1'b0;
    #1;
    total++;
    if ({q2.count_out, q2.out_valid} !== 3'b000) begin
      bad++; $display("FAIL single_drain cnt=%0d vld=%b want 0/0", q2.count_out, q2.out_valid);
    end
  endtask

  task automatic test_fill_wrap2();
    logic [11:0] exp[$];
    int sent, got;
    q2.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q2.in_valid = 1'b1; q2.pc_in = 12'(12'h100 + i); q2.instr_in = 12'(12'h300 + i); q2.instr_set_in = ISET_R;
      #1;
      total++;
      if (q2.in_ready !== (i < 2)) begin
        bad++; $display("FAIL fill2_ready offer=%0d got=%b want=%b", i, q2.in_ready, (i < 2));
      end
      tick();
    end
    q2.in_valid = 1'b0;
    #1;
    total++;
    if ({q2.count_out, q2.in_ready, q2.pc_out} !== {2'd2, 1'b0, 12'h100}) begin
      bad++; $display("FAIL fill2_full cnt=%0d rdy=%b pc=%h want 2/0/100", q2.count_out, q2.in_ready, q2.pc_out);
    end
    exp.push_back(12'h100); exp.push_back(12'h101);
    sent = 0; got = 0;
    q2.out_ready = 1'b1;
    for (int c = 0; c < 60 && got < 10; c++) begin
      q2.in_valid = (sent < 8); q2.pc_in = 12'(12'h200 + sent); q2.instr_in = 12'(12'h300 + sent);
      #1;
      if (q2.out_valid) begin
        total++;
        if (exp.size() == 0 || q2.pc_out !== exp[0]) begin
          bad++; $display("FAIL stream2_order got=%h want=%h", q2.pc_out, (exp.size() != 0) ? exp[0] : 12'hxxx);
        end
        if (exp.size() != 0) void'(exp.pop_front());
        got++;
      end
      if (q2.in_valid && q2.in_ready) begin
        exp.push_back(12'(12'h200 + sent));
        sent++;
      end
      tick();
    end
    q2.in_valid = 1'b0; q2.out_ready = 1'b0;
    #1;
    total++;
    if (got != 10 || sent != 8 || q2.count_out !== 2'd0) begin
      bad++; $display("FAIL stream2_total got=%0d sent=%0d cnt=%0d want 10/8/0", got, sent, q2.count_out);
    end
  endtask

  task automatic test_fill_wrap3();
    logic [11:0] exp[$];
    int sent, got;
    q3.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q3.in_valid = 1'b1; q3.pc_in = 12'(12'h180 + i); q3.instr_in = 12'(12'h400 + i); q3.instr_set_in = ISET_R;
      #1;
      total++;
      if (q3.in_ready !== (i < 3)) begin
        bad++; $display("FAIL fill3_ready offer=%0d got=%b want=%b", i, q3.in_ready, (i < 3));
      end
      tick();
    end
    q3.in_valid = 1'b0;
    #1;
    total++;
    if ({q3.count_out, q3.in_ready, q3.pc_out} !== {2'd3, 1'b0, 12'h180}) begin
      bad++; $display("FAIL fill3_full cnt=%0d rdy=%b pc=%h want 3/0/180", q3.count_out, q3.in_ready, q3.pc_out);
    end
    exp.push_back(12'h180); exp.push_back(12'h181); exp.push_back(12'h182);
    sent = 0; got = 0;
    q3.out_ready = 1'b1;
    for (int c = 0; c < 60 && got < 11; c++) begin
      q3.in_valid = (sent < 8); q3.pc_in = 12'(12'h280 + sent); q3.instr_in = 12'(12'h400 + sent);
      #1;
      if (q3.out_valid) begin
        total++;
        if (exp.size() == 0 || q3.pc_out !== exp[0]) begin
          bad++; $display("FAIL stream3_order got=%h want=%h", q3.pc_out, (exp.size() != 0) ? exp[0] : 12'hxxx);
        end
        if (exp.size() != 0) void'(exp.pop_front());
        got++;
      end
      if (q3.in_valid && q3.in_ready) begin
        exp.push_back(12'(12'h280 + sent));
        sent++;
      end
      tick();
    end
    q3.in_valid = 1'b0; q3.out_ready = 1'b0;
    #1;
    total++;
    if (got != 11 || sent != 8 || q3.count_out !== 2'd0) begin
      bad++; $display("FAIL stream3_total got=%0d sent=%0d cnt=%0d want 11/8/0", got, sent, q3.count_out);
    end
  endtask

  task automatic test_stall();
    load2(12'h020, 12'h5AB, ISET_R);
    q2.stall_in = 1'b1; q2.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if ({q2.out_valid, q2.pc_out, q2.instr_out, q2.instr_set_out, q2.count_out} !== {1'b0, 12'h020, 12'h000, ISET_R, 2'd1}) begin
        bad++; $display("FAIL stall_bubble cyc=%0d vld=%b pc=%h instr=%h set=%h cnt=%0d", c, q2.out_valid, q2.pc_out, q2.instr_out, q2.instr_set_out, q2.count_out);
      end
      total++;
      if (fields2() !== 35'h0) begin
        bad++; $display("FAIL stall_fields cyc=%0d got=%h want=0", c, fields2());
      end
      tick();
    end
    q2.stall_in = 1'b0;
    #1;
    total++;
    if ({q2.out_valid, q2.pc_out, q2.instr_out, q2.tgt_gp_out, q2.src_gp_out} !== {1'b1, 12'h020, 12'h5AB, 4'hA, 4'hB}) begin
      bad++; $display("FAIL stall_release vld=%b pc=%h instr=%h tgt=%h src=%h", q2.out_valid, q2.pc_out, q2.instr_out, q2.tgt_gp_out, q2.src_gp_out);
    end
    tick();
    q2.out_ready = 1'b0;
    #1;
    total++;
    if (q2.count_out !== 2'd0) begin
      bad++; $display("FAIL stall_drain cnt=%0d want 0", q2.count_out);
    end
  endtask

  task automatic test_flush();
    load2(12'h030, 12'h312, ISET_R);
    load2(12'h031, 12'h312, ISET_R);
    q2.in_valid = 1'b1; q2.pc_in = 12'h0EE; q2.instr_in = 12'h312; q2.out_ready = 1'b1; q2.flush_in = 1'b1;
    tick();
    q2.in_valid = 1'b0; q2.flush_in = 1'b0; q2.out_ready = 1'b0;
    #1;
    total++;
    if ({q2.count_out, q2.out_valid, q2.in_ready} !== {2'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL flush_full cnt=%0d vld=%b rdy=%b want 0/0/1", q2.count_out, q2.out_valid, q2.in_ready);
    end
    q2.in_valid = 1'b1; q2.pc_in = 12'h0EF; q2.flush_in = 1'b1;
    tick();
    q2.in_valid = 1'b0; q2.flush_in = 1'b0;
    #1;
    total++;
    if ({q2.count_out, q2.out_valid, q2.pc_out} !== {2'd0, 1'b0, 12'h000}) begin
      bad++; $display("FAIL flush_drop cnt=%0d vld=%b pc=%h want 0/0/000", q2.count_out, q2.out_valid, q2.pc_out);
    end
  endtask

  task automatic test_decode();
    logic [11:0] v_instr [5] = '{12'h0FF, 12'h1C5, 12'h1A5, 12'h234, 12'hC9E};
    logic [3:0]  v_set   [5] = '{ISET_R, ISET_S, ISET_I, ISET_IS, ISET_RS};
    logic [11:0] v_out   [5] = '{12'h000, 12'h1C5, 12'h1A5, 12'h234, 12'hC9E};
    logic [34:0] v_fld   [5] = '{
      {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00},
      {4'hC, 4'h0, 4'hC, 4'h0, 4'h5, 1'b0, 1'b1, 1'b0, 6'h05, 6'h05},
      {4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 6'h25, 6'h25},
      {4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 6'h34, 6'h34},
      {4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 6'h1E, 6'h1E}};
    for (int i = 0; i < 5; i++) begin
      load2(12'(12'h050 + i), v_instr[i], v_set[i]);
      total++;
      if ({q2.instr_out, q2.instr_set_out} !== {v_out[i], v_set[i]}) begin
        bad++; $display("FAIL decode_instr vec=%0d instr=%h set=%h want %h/%h", i, q2.instr_out, q2.instr_set_out, v_out[i], v_set[i]);
      end
      total++;
      if (fields2() !== v_fld[i]) begin
        bad++; $display("FAIL decode_fields vec=%0d got=%h want=%h", i, fields2(), v_fld[i]);
      end
      q2.out_ready = 1'b1;
      tick();
      q2.out_ready = 1'b0;
    end
  endtask

  task automatic test_enable();
    load2(12'h040, 12'h312, ISET_R);
    q2.enable_in = 1'b0; q2.in_valid = 1'b1; q2.pc_in = 12'h041; q2.out_ready = 1'b1;
    #1;
    total++;
    if ({q2.out_valid, q2.in_ready, q2.pc_out} !== {1'b0, 1'b0, 12'h040}) begin
      bad++; $display("FAIL enable_low vld=%b rdy=%b pc=%h want 0/0/040", q2.out_valid, q2.in_ready, q2.pc_out);
    end
    tick();
    q2.in_valid = 1'b0;
    #1;
    total++;
    if (q2.count_out !== 2'd1) begin
      bad++; $display("FAIL enable_frozen cnt=%0d want 1", q2.count_out);
    end
    q2.enable_in = 1'b1;
    #1;
    total++;
    if ({q2.out_valid, q2.pc_out} !== {1'b1, 12'h040}) begin
      bad++; $display("FAIL enable_resume vld=%b pc=%h want 1/040", q2.out_valid, q2.pc_out);
    end
    tick();
    q2.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    load2(12'h060, 12'h312, ISET_R);
    load2(12'h061, 12'h1C5, ISET_S);
    total++;
    if (q2.count_out !== 2'd2) begin
      bad++; $display("FAIL areset_preload cnt=%0d want 2", q2.count_out);
    end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({q2.count_out, q2.out_valid, q2.in_ready, q2.pc_out, q2.instr_out, q2.instr_set_out} !==
        {2'd0, 1'b0, 1'b1, 12'h000, 12'h000, ISET_R}) begin
      bad++; $display("FAIL areset_now cnt=%0d vld=%b rdy=%b pc=%h instr=%h set=%h", q2.count_out, q2.out_valid, q2.in_ready, q2.pc_out, q2.instr_out, q2.instr_set_out);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_wrap2();
    test_fill_wrap3();
    test_stall();
    test_flush();
    test_decode();
    test_enable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
